// File: rtl/nmea_time_sender_pkg.sv
// Shared constants, FSM encoding and hex-digit helper for the NMEA time sender.
package nmea_time_sender_pkg;

    localparam logic [7:0] DOLLAR = 8'h24;
    localparam logic [7:0] COMMA  = 8'h2C;
    localparam logic [7:0] STAR   = 8'h2A;
    localparam logic [7:0] CR     = 8'h0D;
    localparam logic [7:0] LF     = 8'h0A;
    localparam logic [7:0] ZERO   = 8'h30;

    localparam int unsigned SENTENCE_LEN = 20;

    // Byte positions inside "$GPxxx,HHMMSS,A*CC\r\n".
    localparam logic [4:0] IDX_CSUM_FIRST = 5'd1;
    localparam logic [4:0] IDX_CSUM_LAST  = 5'd14;
    localparam logic [4:0] IDX_CSUM_HI    = 5'd16;
    localparam logic [4:0] IDX_CSUM_LO    = 5'd17;
    localparam logic [4:0] IDX_LAST       = 5'(SENTENCE_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_HOLD,
        ST_FIN
    } state_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/nmea_time_sender_bin2ascii_2digit.sv
// Saturating binary-to-two-ASCII-digit converter (values up to 59).
module bin2ascii_2digit
    import nmea_time_sender_pkg::*;
#(
    parameter int unsigned MAX = 59
) (
    input  logic [5:0] value,
    output logic [7:0] tens_ascii,
    output logic [7:0] units_ascii
);

    logic [5:0] sat;
    logic [3:0] tens;
    logic [6:0] units;

    // NOTE: every variable gets a value on every path of always_comb, so no latch is inferred.
    always_comb begin
        sat = (value > 6'(MAX)) ? 6'(MAX) : value;
        if      (sat >= 6'd50) tens = 4'd5;
        else if (sat >= 6'd40) tens = 4'd4;
        else if (sat >= 6'd30) tens = 4'd3;
        else if (sat >= 6'd20) tens = 4'd2;
        else if (sat >= 6'd10) tens = 4'd1;
        else                   tens = 4'd0;
        units = {1'b0, sat} - ({tens, 3'b000} + {2'b00, tens, 1'b0});
        tens_ascii  = ZERO + {4'h0, tens};
        units_ascii = ZERO + {4'h0, units[3:0]};
    end

endmodule

// File: rtl/nmea_time_sender.sv
// Emits "$GPRMC,HHMMSS,A*CC\r\n" or "$GPGGA,HHMMSS,1*CC\r\n" byte by byte via a UART handshake.
module nmea_time_sender
    import nmea_time_sender_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sel_gga,
    input  logic [4:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_new,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] HOLD_LAST = 3'(HOLD_CYCLES - 1);

    state_t          state, state_nxt;
    logic            sel_q;
    logic [4:0]      hours_q;
    logic [5:0]      minutes_q, seconds_q;
    logic [5:0][7:0] conv, time_q;   // [5]=H1 ... [0]=S0
    logic [4:0]      idx;
    logic [2:0]      hold_cnt;
    logic [7:0]      csum;
    logic [7:0]      cur_byte;
    logic            strobe;

    bin2ascii_2digit #(.MAX(23)) u_hours (
        .value({1'b0, hours_q}), .tens_ascii(conv[5]), .units_ascii(conv[4])
    );
    bin2ascii_2digit #(.MAX(59)) u_minutes (
        .value(minutes_q), .tens_ascii(conv[3]), .units_ascii(conv[2])
    );
    bin2ascii_2digit #(.MAX(59)) u_seconds (
        .value(seconds_q), .tens_ascii(conv[1]), .units_ascii(conv[0])
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_SEND;
            ST_SEND: if (!tx_busy) state_nxt = ST_HOLD;
            ST_HOLD: if (hold_cnt == HOLD_LAST) state_nxt = (idx == IDX_LAST) ? ST_FIN : ST_SEND;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != ST_IDLE);
        done   = (state == ST_FIN);
        strobe = (state == ST_SEND) && !tx_busy;
    end

    always_comb begin
        cur_byte = ZERO;
        case (idx)
            5'd0:    cur_byte = DOLLAR;
            5'd1:    cur_byte = "G";
            5'd2:    cur_byte = "P";
            5'd3:    cur_byte = sel_q ? "G" : "R";
            5'd4:    cur_byte = sel_q ? "G" : "M";
            5'd5:    cur_byte = sel_q ? "A" : "C";
            5'd6:    cur_byte = COMMA;
            5'd7:    cur_byte = time_q[5];
            5'd8:    cur_byte = time_q[4];
            5'd9:    cur_byte = time_q[3];
            5'd10:   cur_byte = time_q[2];
            5'd11:   cur_byte = time_q[1];
            5'd12:   cur_byte = time_q[0];
            5'd13:   cur_byte = COMMA;
            5'd14:   cur_byte = sel_q ? "1" : "A";
            5'd15:   cur_byte = STAR;
            5'd16:   cur_byte = hex_ascii(csum[7:4]);
            5'd17:   cur_byte = hex_ascii(csum[3:0]);
            5'd18:   cur_byte = CR;
            5'd19:   cur_byte = LF;
            default: cur_byte = ZERO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q     <= 1'b0;
            hours_q   <= '0;
            minutes_q <= '0;
            seconds_q <= '0;
            time_q    <= '0;
            idx       <= '0;
            hold_cnt  <= '0;
            csum      <= '0;
            tx_data   <= '0;
            tx_new    <= 1'b0;
        end else begin
            tx_new <= strobe;
            if (state == ST_IDLE && start) begin
                sel_q     <= sel_gga;
                hours_q   <= hours;
                minutes_q <= minutes;
                seconds_q <= seconds;
                idx       <= '0;
                csum      <= '0;
            end
            if (state == ST_LOAD) begin
                time_q <= conv;
                csum   <= '0;
            end
            // The checksum is complete before index 16 is reached, so C1/C0 read a settled value.
            if (strobe) begin
                tx_data  <= cur_byte;
                hold_cnt <= '0;
                if (idx >= IDX_CSUM_FIRST && idx <= IDX_CSUM_LAST)
                    csum <= csum ^ cur_byte;
            end
            if (state == ST_HOLD) begin
                hold_cnt <= hold_cnt + 3'd1;
                if (hold_cnt == HOLD_LAST && idx != IDX_LAST)
                    idx <= idx + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_nmea_time_sender.sv
// Directed bench for nmea_time_sender: sentence vectors plus restart and mid-sentence reset sequences.
module tb_nmea_time_sender;

    localparam int HOLD = 1;

    logic       clk = 1'b0;
    logic       rst, start, sel_gga, tx_busy;
    logic [4:0] hours;
    logic [5:0] minutes, seconds;
    logic [7:0] tx_data;
    logic       tx_new, busy, done;

    always #5 clk = ~clk;

    nmea_time_sender #(.HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .start(start), .sel_gga(sel_gga),
        .hours(hours), .minutes(minutes), .seconds(seconds),
        .tx_busy(tx_busy), .tx_data(tx_data), .tx_new(tx_new),
        .busy(busy), .done(done)
    );

    // UART busy model: busy for busy_len cycles after each accepted strobe.
    int busy_len = 0;
    int bcnt = 0;
    int cyc = 0;
    assign tx_busy = (bcnt != 0);
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst)              bcnt <= 0;
        else if (tx_new)      bcnt <= busy_len;
        else if (bcnt != 0)   bcnt <= bcnt - 1;
    end

    logic [7:0] cap [0:31];
    int cap_n = 0, done_n = 0, viol = 0, last_new = -1000, min_gap = 2;
    bit exact_gap = 1'b1;

    always @(negedge clk) begin
        if (tx_new) begin
            if (cap_n < 32) cap[cap_n] = tx_data;
            if (tx_busy) viol++;
            if (cap_n > 0) begin
                if ((cyc - last_new) < min_gap) viol++;
                if (exact_gap && (cyc - last_new) != min_gap) viol++;
            end
            last_new = cyc;
            cap_n++;
        end
        if (done) begin
            done_n++;
            if (cap_n != 20) viol++;
        end
    end

    int n_checks = 0, n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic         sel;
        logic [4:0]   h;
        logic [5:0]   m;
        logic [5:0]   s;
        int           busy_len;
        int           restart_at;
        logic [159:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input int k, input vec_t v);
        int  t0, t_done;
        bit  restarted;
        logic [7:0] eb;
        restarted = 1'b0;
        busy_len  = v.busy_len;
        min_gap   = (v.busy_len == 0) ? HOLD + 1 : v.busy_len + 1;
        exact_gap = (v.busy_len == 0);
        cap_n = 0; done_n = 0; viol = 0;
        sel_gga = v.sel; hours = v.h; minutes = v.m; seconds = v.s;
        start = 1'b1;
        t0 = cyc;
        step();
        start = 1'b0;
        // Scramble inputs after the latch; they must have no effect.
        sel_gga = ~v.sel; hours = 5'd3; minutes = 6'd7; seconds = 6'd1;
        check($sformatf("v%0d busy after start", k), 32'(busy), 32'd1);
        for (int b = 0; b < 2000 && done_n == 0; b++) begin
            if (v.restart_at >= 0 && !restarted && cap_n == v.restart_at) begin
                restarted = 1'b1;
                sel_gga = ~v.sel; hours = 5'd9; minutes = 6'd9; seconds = 6'd9;
                start = 1'b1;
                step();
                start = 1'b0;
            end else begin
                step();
            end
        end
        t_done = cyc;
        check($sformatf("v%0d done seen", k), 32'(done_n != 0), 32'd1);
        step();
        step();
        check($sformatf("v%0d byte count", k), 32'(cap_n), 32'd20);
        check($sformatf("v%0d done pulses", k), 32'(done_n), 32'd1);
        check($sformatf("v%0d handshake violations", k), 32'(viol), 32'd0);
        check($sformatf("v%0d busy cleared", k), 32'(busy), 32'd0);
        check($sformatf("v%0d tx_data holds LF", k), 32'(tx_data), 32'h0A);
        for (int i = 0; i < 20; i++) begin
            eb = v.exp[159 - 8*i -: 8];
            check($sformatf("v%0d byte %0d", k, i), 32'(cap[i]), 32'(eb));
        end
        if (v.busy_len > 0)
            check($sformatf("v%0d sentence time >= 220", k), 32'(t_done - t0 >= 220), 32'd1);
    endtask

    initial begin
        vecs[0] = '{1'b0, 5'd12, 6'd34, 6'd56, 0,  -1, "$GPRMC,123456,A*0D\r\n"};
        vecs[1] = '{1'b1, 5'd0,  6'd0,  6'd0,  0,  -1, "$GPGGA,000000,1*67\r\n"};
        vecs[2] = '{1'b0, 5'd31, 6'd63, 6'd63, 0,  -1, "$GPRMC,235959,A*0B\r\n"};
        vecs[3] = '{1'b0, 5'd12, 6'd34, 6'd56, 10, -1, "$GPRMC,123456,A*0D\r\n"};
        vecs[4] = '{1'b0, 5'd12, 6'd34, 6'd56, 0,  5,  "$GPRMC,123456,A*0D\r\n"};
        vecs[5] = '{1'b1, 5'd7,  6'd8,  6'd9,  0,  -1, "$GPGGA,070809,1*61\r\n"};

        rst = 1'b1; start = 1'b0; sel_gga = 1'b0;
        hours = '0; minutes = '0; seconds = '0;
        repeat (3) step();
        check("reset tx_new", 32'(tx_new), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset tx_data", 32'(tx_data), 32'd0);
        rst = 1'b0;
        step();

        for (int k = 0; k < 5; k++) run_vec(k, vecs[k]);

        // Mid-sentence reset after eight bytes have been strobed.
        busy_len = 0; min_gap = HOLD + 1; exact_gap = 1'b1;
        cap_n = 0; done_n = 0; viol = 0;
        sel_gga = 1'b0; hours = 5'd12; minutes = 6'd34; seconds = 6'd56;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int b = 0; b < 500 && cap_n < 8; b++) step();
        check("pre-reset byte count", 32'(cap_n), 32'd8);
        rst = 1'b1;
        #1;
        check("rst tx_new immediate", 32'(tx_new), 32'd0);
        check("rst busy immediate", 32'(busy), 32'd0);
        repeat (4) step();
        check("no bytes during reset", 32'(cap_n), 32'd8);
        check("no done during reset", 32'(done_n), 32'd0);
        check("rst tx_data cleared", 32'(tx_data), 32'd0);
        rst = 1'b0;
        step();
        run_vec(5, vecs[5]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
